writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 107 ++++++++++
 tb/tb_writeback_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry write buffer between MEMORY and the IDECODE register-file write port.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        MEM_WB_regwrite_in,
  input  logic        MEM_WB_memtoreg_in,
  input  logic [31:0] read_data,
  input  logic [31:0] mem_alu_result,
  input  logic [4:0]  mem_write_reg,
  input  logic        wb_flush,
  input  logic        rf_ready,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] WB_mux5_writedata,
  output logic        wb_stall,
  output logic        wb_overflow
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t       mem_q [2];
  logic [CW-1:0]   count_q;
  logic            head_q;
  logic            tail_q;
  logic            overflow_q;

  logic            pop_c;
  logic            qual_c;
  logic            full_c;
  logic            push_c;
  logic            drop_c;
  wb_entry_t       entry_c;

  // Push/pop qualification; a pop in the same cycle frees the slot for a push.
  always_comb begin
    pop_c        = (count_q != CW'(0)) && rf_ready;
    qual_c       = mem_valid && MEM_WB_regwrite_in && (mem_write_reg != RW'(0));
    full_c       = (count_q == CW'(2)) && !pop_c;
    push_c       = qual_c && !full_c;
    drop_c       = qual_c && full_c;
    entry_c.rd   = mem_write_reg;
    entry_c.data = MEM_WB_memtoreg_in ? read_data : mem_alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      overflow_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else if (wb_flush) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[tail_q] <= entry_c;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop_c) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head entry drives the register-file write port; zero when empty.
  assign MEM_WB_regwrite   = (count_q != CW'(0));
  assign MEM_WB_rd         = MEM_WB_regwrite ? mem_q[head_q].rd   : '0;
  assign WB_mux5_writedata = MEM_WB_regwrite ? mem_q[head_q].data : '0;
  assign wb_stall          = full_c;
  assign wb_overflow       = overflow_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_q;

  // Counts every mem_valid cycle except overflow drops and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (mem_valid && !wb_flush && !drop_c) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (also covers WB_RETIRE_COUNT_EN when defined).
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        MEM_WB_regwrite_in;
  logic        MEM_WB_memtoreg_in;
  logic [31:0] read_data;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_write_reg;
  logic        wb_flush;
  logic        rf_ready;
  logic        MEM_WB_regwrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] WB_mux5_writedata;
  logic        wb_stall;
  logic        wb_overflow;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_retire = 0;

  writeback_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_valid          (mem_valid),
    .MEM_WB_regwrite_in (MEM_WB_regwrite_in),
    .MEM_WB_memtoreg_in (MEM_WB_memtoreg_in),
    .read_data          (read_data),
    .mem_alu_result     (mem_alu_result),
    .mem_write_reg      (mem_write_reg),
    .wb_flush           (wb_flush),
    .rf_ready           (rf_ready),
    .MEM_WB_regwrite    (MEM_WB_regwrite),
    .MEM_WB_rd          (MEM_WB_rd),
    .WB_mux5_writedata  (WB_mux5_writedata),
    .wb_stall           (wb_stall),
    .wb_overflow        (wb_overflow)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count       (retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic rw, input logic [4:0] rd,
                            input logic [31:0] data);
    check({tag, ".regwrite"}, 32'(MEM_WB_regwrite), 32'(rw));
    check({tag, ".rd"}, 32'(MEM_WB_rd), 32'(rd));
    check({tag, ".data"}, WB_mux5_writedata, data);
  endtask

  task automatic check_retire(input string tag);
`ifdef WB_RETIRE_COUNT_EN
    check({tag, ".retire"}, retire_count, 32'(exp_retire));
`else
    n_checks = n_checks + 0;
`endif
  endtask

  // Advance one clock: inputs were set at negedge, capture on posedge, return at next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld);
    mem_valid          = v;
    MEM_WB_regwrite_in = rw;
    MEM_WB_memtoreg_in = m2r;
    mem_write_reg      = rd;
    mem_alu_result     = alu;
    read_data          = ld;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_flush = 1'b0;
    rf_ready = 1'b1;
    idle();
    #12;
    check_port("reset", 1'b0, 5'd0, 32'h0);
    check("reset.stall", 32'(wb_stall), 32'd0);
    check("reset.overflow", 32'(wb_overflow), 32'd0);
    check_retire("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("release.regwrite", 32'(MEM_WB_regwrite), 32'd0);

    // ALU writeback, one-cycle latency, then drained
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'hAAAA_0000);
    step(); exp_retire++;
    idle();
    check_port("alu", 1'b1, 5'd5, 32'h1234);
    step();
    check_port("alu_empty", 1'b0, 5'd0, 32'h0);
    check_retire("alu");

    // Load writeback selects read_data
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h5555, 32'hDEAD_BEEF);
    step(); exp_retire++;
    idle();
    check_port("load", 1'b1, 5'd9, 32'hDEAD_BEEF);
    step();
    check_port("load_empty", 1'b0, 5'd0, 32'h0);

    // $0 destination and regwrite=0 are discarded but still retire
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0);
    step(); exp_retire++;
    check("rd0.regwrite", 32'(MEM_WB_regwrite), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h88, 32'h0);
    step(); exp_retire++;
    idle();
    check("norw.regwrite", 32'(MEM_WB_regwrite), 32'd0);
    check_retire("discard");

    // Backpressure: fill, overflow drops rd=3, drain in order
    rf_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h11, 32'h0);
    step(); exp_retire++;
    check("bp1.stall", 32'(wb_stall), 32'd0);
    check_port("bp1", 1'b1, 5'd1, 32'h11);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h22, 32'h0);
    step(); exp_retire++;
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    #1;
    check("bp2.stall", 32'(wb_stall), 32'd1);
    check("bp2.overflow", 32'(wb_overflow), 32'd0);
    step();
    idle();
    check("bp3.overflow", 32'(wb_overflow), 32'd1);
    check_port("bp3", 1'b1, 5'd1, 32'h11);
    check_retire("bp3");
    rf_ready = 1'b1;
    #1;
    check("bp_pop.stall", 32'(wb_stall), 32'd0);
    step();
    check_port("drain2", 1'b1, 5'd2, 32'h22);
    step();
    check_port("drain_empty", 1'b0, 5'd0, 32'h0);

    // Simultaneous push and pop while full keeps count at 2
    rf_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h0);
    step(); exp_retire++;
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
    step(); exp_retire++;
    rf_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0);
    #1;
    check("pp.stall", 32'(wb_stall), 32'd0);
    step(); exp_retire++;
    idle();
    rf_ready = 1'b0;
    #1;
    check("pp_full.stall", 32'(wb_stall), 32'd1);
    check_port("pp_head", 1'b1, 5'd6, 32'h66);
    rf_ready = 1'b1;
    step();
    check_port("pp_next", 1'b1, 5'd7, 32'h77);
    step();
    check_port("pp_empty", 1'b0, 5'd0, 32'h0);
    check_retire("pp");

    // Flush discards buffered writes and ignores a same-cycle push
    rf_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd10, 32'hA0, 32'h0);
    step(); exp_retire++;
    drive(1'b1, 1'b1, 1'b0, 5'd11, 32'hB0, 32'h0);
    step(); exp_retire++;
    drive(1'b1, 1'b1, 1'b0, 5'd12, 32'hC0, 32'h0);
    wb_flush = 1'b1;
    step();
    wb_flush = 1'b0;
    idle();
    check_port("flush", 1'b0, 5'd0, 32'h0);
    check("flush.stall", 32'(wb_stall), 32'd0);
    check_retire("flush");

    // Asynchronous reset mid-drain
    drive(1'b1, 1'b1, 1'b0, 5'd13, 32'hD0, 32'h0);
    step(); exp_retire++;
    drive(1'b1, 1'b1, 1'b0, 5'd14, 32'hE0, 32'h0);
    step(); exp_retire++;
    idle();
    rf_ready = 1'b1;
    step();
    check_port("mid_drain", 1'b1, 5'd14, 32'hE0);
    #2;
    rst_n = 1'b0;
    exp_retire = 0;
    #1;
    check_port("async_rst", 1'b0, 5'd0, 32'h0);
    check("async_rst.overflow", 32'(wb_overflow), 32'd0);
    check_retire("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_release.regwrite", 32'(MEM_WB_regwrite), 32'd0);

    // Post-reset latency
    drive(1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0);
    step(); exp_retire++;
    idle();
    check_port("post_rst", 1'b1, 5'd31, 32'hFFFF_FFFF);
    check_retire("post_rst");
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
